// File: rtl/phase_unwrap_if.sv
// Phase stream interface between the atan stage and the unwrapper.
// The unwrapper takes one sample per clock and has no handshake.
interface phase_unwrap_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12
);
    logic signed [IN_W-1:0]  inphase;
    logic signed [OUT_W-1:0] outphase;

    modport master (output inphase, input  outphase);
    modport slave  (input  inphase, output outphase);
endinterface

// File: rtl/phase_unwrap.sv
// Phase unwrapper: removes 2*PI jumps from a wrapped phase stream using a
// running offset, so the downstream FM discriminator sees a continuous phase.
module phase_unwrap #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12,
    parameter int PI    = 804
) (
    input  logic            clk,
    input  logic            rst_n,
    phase_unwrap_if.slave   bus
);
    localparam logic signed [IN_W:0]  PI_D   = (IN_W+1)'(PI);
    localparam logic        [OUT_W-1:0] TWO_PI = OUT_W'(2 * PI);

    typedef enum logic {ST_FIRST, ST_RUN} state_t;

    state_t                  r_state;
    logic signed [IN_W-1:0]  r_prev;
    logic        [OUT_W-1:0] r_offset;
    logic        [OUT_W-1:0] r_out;

    logic signed [IN_W:0]    w_d;
    logic        [OUT_W-1:0] w_k;
    logic        [OUT_W-1:0] w_in_ext;

    always_comb begin
        w_d      = (IN_W+1)'(bus.inphase) - (IN_W+1)'(r_prev);
        w_in_ext = OUT_W'(bus.inphase);
        w_k      = r_offset;
        // Strict compares: a jump of exactly PI is a legitimate step, not a wrap.
        if (r_state == ST_RUN) begin
            if (w_d > PI_D)
                w_k = r_offset - TWO_PI;
            else if (w_d < -PI_D)
                w_k = r_offset + TWO_PI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FIRST;
            r_prev   <= '0;
            r_offset <= '0;
            r_out    <= '0;
        end else begin
            r_state  <= ST_RUN;
            r_prev   <= bus.inphase;
            r_offset <= w_k;
            r_out    <= w_in_ext + w_k;
        end
    end

    assign bus.outphase = r_out;

endmodule

// File: tb/tb_phase_unwrap.sv
// Directed bench for phase_unwrap: reset, ramp, wraps, PI edges, offset wrap
// against an accumulated true-phase model, and reset mid-stream.
module tb_phase_unwrap;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    phase_unwrap_if #(.IN_W(12), .OUT_W(12)) bus ();

    phase_unwrap #(.IN_W(12), .OUT_W(12), .PI(804)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [11:0] exp);
        checks++;
        assert (bus.outphase === exp)
        else begin
            errors++;
            $error("FAIL %s: outphase=%0d expected=%0d", tag, bus.outphase, exp);
        end
    endtask

    // Apply one sample, clock it in, then check the registered output.
    task automatic step(input string tag, input int value, input int exp);
        bus.inphase = 12'(value);
        @(posedge clk);
        #1;
        check(tag, 12'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int truep;
        int wrapped;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.inphase = '0;

        // Reset holds output and offset at zero regardless of input
        for (int i = 0; i < 4; i++) begin
            bus.inphase = 12'(i * 300 - 500);
            @(posedge clk);
            #1;
            check("reset_out", 12'sd0);
        end
        checks++;
        assert (dut.r_offset === 12'd0)
        else begin
            errors++;
            $error("FAIL reset_offset: offset=%0d expected=0", dut.r_offset);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp: no correction, output follows input
        step("ramp0", 0, 0);
        step("ramp1", 0, 0);
        step("ramp2", 16, 16);
        step("ramp3", 32, 32);
        step("ramp4", 64, 64);
        step("ramp5", 128, 128);
        step("ramp6", 256, 256);
        step("ramp7", 512, 512);
        step("ramp8", 1024, 1024);

        // Positive wrap
        step("pwrap_a", 700, 700);
        step("pwrap_b", -700, 908);
        step("pwrap_c", -600, 1008);
        step("const_a", -600, 1008);
        step("const_b", -600, 1008);

        // Negative wrap from fresh state
        do_reset();
        step("nwrap_a", -700, -700);
        step("nwrap_b", 700, -908);

        // Exactly PI: no correction
        do_reset();
        step("pi_a", 0, 0);
        step("pi_b", 804, 804);
        step("pi_c", 0, 0);
        step("pi_d", 805, -803);

        // Rising phase 400/sample: offset climbs by 1608 per wrap past 2047
        do_reset();
        for (int n = 0; n < 20; n++) begin
            truep   = 400 * n;
            wrapped = truep;
            while (wrapped > 804) wrapped -= 1608;
            step("offwrap", wrapped, truep);
        end

        // Asynchronous reset mid-stream clears offset
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 12'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", -700, -700);
        step("post_rst2", -650, -650);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
